if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined RV32I core, directly upstream of the decode stage that feeds the control unit.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched word into the IF/ID pipeline register.
- Handles stalls, branch/jump redirects and flush bubbles, and freezes fetch when decode reports a halt (SYSTEM opcode).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) placed in IF/ID on flush

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID
redirect_valid  in  1  EX stage: branch taken or JAL/JALR resolved
redirect_pc  in  32  redirect target
halt  in  1  Halt from decode control for the instruction currently in IF/ID
imem_addr  out  32  instruction-memory address, combinational = pc
imem_rdata  in  32  instruction word, valid same cycle as imem_addr
ifid_pc  out  32  PC of instruction in IF/ID
ifid_pc_plus4  out  32  ifid_pc + 4
ifid_instr  out  32  instruction in IF/ID
ifid_valid  out  1  IF/ID holds a real instruction
halted  out  1  fetch frozen after halt

Behaviour:
- Reset (rst=1 at edge, overrides everything, including mid-stall or HALTED):
  - pc=RESET_PC, ifid_pc=0, ifid_pc_plus4=0, ifid_instr=NOP_INSTR, ifid_valid=0, halted=0, state=RUN.
- States: RUN, HALTED. halted = (state==HALTED), registered.
- The effective halt is halt & ifid_valid; halt on a bubble is ignored.
- RUN, per-edge priority: redirect_valid > effective halt > stall > advance.
  - Redirect:
    - pc <= {redirect_pc[31:2],2'b00}.
    - IF/ID <= bubble: instr=NOP_INSTR, valid=0, pc fields hold old values.
    - Ignores a stall or halt in the same cycle; the halting instruction is younger than the branch and is squashed.
  - Halt:
    - state <= HALTED, pc holds, IF/ID <= bubble.
    - Wins over stall.
  - Stall: pc and all IF/ID fields hold.
  - Advance:
    - ifid_pc <= pc, ifid_pc_plus4 <= pc+4, ifid_instr <= imem_rdata, ifid_valid <= 1.
    - pc <= pc+4.
- Latency: an instruction appears in IF/ID one cycle after its address is driven. Redirect-to-first-valid-target is 2 edges.
- HALTED:
  - pc frozen, IF/ID bubble held.
  - stall, redirect_valid and halt are ignored.
  - Only rst exits.
- Arithmetic:
  - pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
  - No misalignment trap; low 2 bits of redirect are forced to zero.
- imem_addr is always pc, including while stalled or halted. The memory is read-only from this block.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - Adds output fetch_count[31:0], reset 0.
  - Increments by 1 on every advance edge only; not on stall, redirect, halt, HALTED or reset cycles.
  - Wraps at 2^32.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0x100, memory word[0x100]=0xAAAA_0013 -> after release, imem_addr=0x100. Next edge: ifid_pc=0x100, ifid_instr=0xAAAA_0013, ifid_valid=1, ifid_pc_plus4=0x104, pc=0x104.
- Stall held 3 cycles at pc=0x108 -> imem_addr stays 0x108 and IF/ID unchanged for 3 edges. Fetch resumes with 0x108 on the first unstalled edge.
- redirect_valid=1, redirect_pc=0x203 together with stall=1 -> pc=0x200, IF/ID=NOP_INSTR with valid=0. Next edge: ifid_pc=0x200, valid=1.
- halt=1 with ifid_valid=1, no redirect -> halted=1 next edge, pc frozen, ifid_valid=0. Later redirect_valid pulses and stall toggles cause no change until rst, after which pc=RESET_PC and halted=0.
- halt=1 and redirect_valid=1 (redirect_pc=0x40) same cycle -> state stays RUN, halted=0, pc=0x40, bubble. Also halt=1 with ifid_valid=0 -> ignored.
- Redirect to 0xFFFF_FFFC then advance -> ifid_pc=0xFFFF_FFFC, ifid_pc_plus4=0, pc=0. With FETCH_PERF_CNT_EN defined, fetch_count increments only on advance edges across all prior scenarios.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: RV32I instruction fetch, PC register and IF/ID pipeline register.
// Optional macro FETCH_PERF_CNT_EN adds the fetch_count advance counter output.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
`endif
    output logic        halted
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        halt_eff, advance;
    // A halt reported for a bubble carries no instruction and must not freeze fetch.
    assign halt_eff = halt & ifid_valid_q;
    assign advance  = (state_q == RUN) & ~redirect_valid & ~halt_eff & ~stall;
    // Next-state: redirect beats halt beats stall beats advance; HALTED holds everything.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_valid_d    = ifid_valid_q;
        if (state_q == RUN) begin
            if (redirect_valid) begin
                pc_d         = {redirect_pc[31:2], 2'b00};
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end else if (halt_eff) begin
                state_d      = HALTED;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end else if (!stall) begin
                ifid_pc_d       = pc_q;
                ifid_pc_plus4_d = pc_q + 32'd4;
                ifid_instr_d    = imem_rdata;
                ifid_valid_d    = 1'b1;
                pc_d            = pc_q + 32'd4;
            end
        end
    end
    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            pc_q            <= RESET_PC;
            ifid_pc_q       <= 32'h0;
            ifid_pc_plus4_q <= 32'h0;
            ifid_instr_q    <= NOP_INSTR;
            ifid_valid_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_valid_q    <= ifid_valid_d;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    // Counts only edges on which a new instruction enters IF/ID.
    always_ff @(posedge clk) begin
        if (rst) fetch_count_q <= 32'h0;
        else if (advance) fetch_count_q <= fetch_count_q + 32'd1;
    end
    assign fetch_count = fetch_count_q;
`endif
    assign imem_addr     = pc_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_valid    = ifid_valid_q;
    assign halted        = (state_q == HALTED);
endmodule
